// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled frame recovery with parity/stop checking,
// a single-word holding register and RTS flow control.
module uart_receiver #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       baud_clock,
    input  logic       reset,
    input  logic       serial_data_in,
    input  logic       MCR1,
    input  logic [3:0] data_length,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic [1:0] num_stop_bit,
    input  logic       data_read,
    output logic [8:0] data_out,
    output logic       data_valid,
    output logic       rx_full,
    output logic       parity_error,
    output logic       framing_error,
    output logic       break_detect,
    output logic       overrun_error,
    output logic       n_RTS
);

    localparam logic [3:0] MID_SAMPLE  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t     state;
    logic       sync1;
    logic       rx_s;
    logic [3:0] clk_counter;
    logic [3:0] bit_counter;
    logic       stop_counter;
    logic [3:0] len_q;
    logic       two_stop_q;
    logic       par_en_q;
    logic       par_odd_q;
    logic [8:0] shift_q;
    logic       par_acc;
    logic       stop_fail;
    logic       all_zero;
    logic       armed;
    logic       done;

    always_ff @(posedge baud_clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= serial_data_in;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge baud_clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            clk_counter   <= '0;
            bit_counter   <= '0;
            stop_counter  <= 1'b0;
            len_q         <= 4'd8;
            two_stop_q    <= 1'b0;
            par_en_q      <= 1'b0;
            par_odd_q     <= 1'b0;
            shift_q       <= '0;
            par_acc       <= 1'b0;
            stop_fail     <= 1'b0;
            all_zero      <= 1'b0;
            armed         <= 1'b1;
            done          <= 1'b0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            rx_full       <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            break_detect  <= 1'b0;
            overrun_error <= 1'b0;
            n_RTS         <= 1'b1;
        end else begin
            data_valid <= 1'b0;
            done       <= 1'b0;
            n_RTS      <= !(MCR1 && !rx_full);
            if (rx_s)
                armed <= 1'b1;

            // Frame results sit in the working registers for one cycle after
            // the last stop sample; nothing touches them until DATA entry.
            if (done) begin
                data_out      <= shift_q;
                parity_error  <= par_en_q && (par_acc != par_odd_q);
                framing_error <= stop_fail;
                break_detect  <= all_zero;
                data_valid    <= 1'b1;
                rx_full       <= 1'b1;
                if (rx_full)
                    overrun_error <= !data_read;
            end else if (data_read && rx_full) begin
                rx_full       <= 1'b0;
                overrun_error <= 1'b0;
            end

            if (!MCR1) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (!rx_s && armed) begin
                            state       <= START;
                            clk_counter <= '0;
                            len_q       <= (data_length >= 4'd5 && data_length <= 4'd9)
                                           ? data_length : 4'd8;
                            two_stop_q  <= (num_stop_bit == 2'b11);
                            par_en_q    <= parity_en;
                            par_odd_q   <= parity_odd;
                        end
                    end
                    START: begin
                        if (clk_counter == MID_SAMPLE) begin
                            clk_counter <= '0;
                            if (rx_s) begin
                                state <= IDLE;
                            end else begin
                                state        <= DATA;
                                bit_counter  <= '0;
                                stop_counter <= 1'b0;
                                shift_q      <= '0;
                                par_acc      <= 1'b0;
                                stop_fail    <= 1'b0;
                                all_zero     <= 1'b1;
                            end
                        end else begin
                            clk_counter <= clk_counter + 4'd1;
                        end
                    end
                    DATA: begin
                        if (clk_counter == LAST_SAMPLE) begin
                            clk_counter          <= '0;
                            shift_q[bit_counter] <= rx_s;
                            par_acc              <= par_acc ^ rx_s;
                            all_zero             <= all_zero & !rx_s;
                            bit_counter          <= bit_counter + 4'd1;
                            if (bit_counter == len_q - 4'd1)
                                state <= par_en_q ? PARITY : STOP;
                        end else begin
                            clk_counter <= clk_counter + 4'd1;
                        end
                    end
                    PARITY: begin
                        if (clk_counter == LAST_SAMPLE) begin
                            clk_counter <= '0;
                            par_acc     <= par_acc ^ rx_s;
                            all_zero    <= all_zero & !rx_s;
                            state       <= STOP;
                        end else begin
                            clk_counter <= clk_counter + 4'd1;
                        end
                    end
                    STOP: begin
                        if (clk_counter == LAST_SAMPLE) begin
                            clk_counter <= '0;
                            stop_fail   <= stop_fail | !rx_s;
                            all_zero    <= all_zero & !rx_s;
                            if (stop_counter == two_stop_q) begin
                                state <= IDLE;
                                done  <= 1'b1;
                                // A break leaves the line low: wait for idle before rearming.
                                if (all_zero && !rx_s)
                                    armed <= 1'b0;
                            end else begin
                                stop_counter <= 1'b1;
                            end
                        end else begin
                            clk_counter <= clk_counter + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized frames checked against a bit-level line model of
// the receiver's expected results, status flags and RTS behaviour.
module tb_uart_receiver;

    logic       baud_clock = 1'b0;
    logic       reset;
    logic       serial_data_in;
    logic       MCR1;
    logic [3:0] data_length;
    logic       parity_en;
    logic       parity_odd;
    logic [1:0] num_stop_bit;
    logic       data_read;
    logic [8:0] data_out;
    logic       data_valid;
    logic       rx_full;
    logic       parity_error;
    logic       framing_error;
    logic       break_detect;
    logic       overrun_error;
    logic       n_RTS;

    int compared   = 0;
    int mismatched = 0;

    int   dv_count;
    int   dv_e;
    logic nrts_at_dv;
    logic nrts_after;

    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_brk;
    logic       exp_full = 1'b0;
    logic       exp_ovr  = 1'b0;
    int         exp_e;
    logic       was_empty;

    uart_receiver #(.OVERSAMPLE(16)) dut (
        .baud_clock    (baud_clock),
        .reset         (reset),
        .serial_data_in(serial_data_in),
        .MCR1          (MCR1),
        .data_length   (data_length),
        .parity_en     (parity_en),
        .parity_odd    (parity_odd),
        .num_stop_bit  (num_stop_bit),
        .data_read     (data_read),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .rx_full       (rx_full),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .break_detect  (break_detect),
        .overrun_error (overrun_error),
        .n_RTS         (n_RTS)
    );

    always #5 baud_clock = ~baud_clock;

    task automatic tick;
        @(posedge baud_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with data_valid monitoring; e is the edge index since line fall.
    task automatic step(input int e);
        tick;
        if (data_valid) begin
            dv_count++;
            dv_e       = e;
            nrts_at_dv = n_RTS;
        end
        if (dv_e >= 0 && e == dv_e + 1)
            nrts_after = n_RTS;
    endtask

    task automatic send_frame(input logic [8:0] value, input logic [3:0] dl, input bit pe,
                              input bit po, input logic [1:0] ns, input bit flip, input bit stop0,
                              input bit rd_sim, input int abort_at, input int mcr_at);
        int L, S, n, body, total, sc, bi;
        logic [8:0] dm;
        logic pbit, s;
        L     = (dl >= 4'd5 && dl <= 4'd9) ? int'(dl) : 8;
        S     = (ns == 2'b11) ? 2 : 1;
        sc    = (ns == 2'b11) ? 32 : (ns == 2'b10) ? 24 : 16;
        dm    = value & 9'((1 << L) - 1);
        pbit  = (^dm) ^ po ^ flip;
        n     = L + int'(pe) + S;
        body  = 1 + L + int'(pe);
        total = 16 * body + sc;
        data_length  = dl;
        parity_en    = pe;
        parity_odd   = po;
        num_stop_bit = ns;
        dv_count   = 0;
        dv_e       = -1;
        nrts_at_dv = 1'bx;
        nrts_after = 1'bx;
        exp_data  = dm;
        exp_perr  = pe && (((^dm) ^ pbit) != po);
        exp_ferr  = stop0;
        exp_brk   = stop0 && (dm == 9'd0) && (!pe || !pbit);
        exp_e     = 12 + 16 * n;
        was_empty = !exp_full;
        for (int k = 0; k < total; k++) begin
            if (k == abort_at) begin
                serial_data_in = 1'b1;
                return;
            end
            if (k == mcr_at)
                MCR1 = 1'b0;
            bi = k / 16;
            if (bi == 0)
                s = 1'b0;
            else if (bi <= L)
                s = dm[bi-1];
            else if (pe && bi == L + 1)
                s = pbit;
            else
                s = !stop0;
            serial_data_in = s;
            data_read      = rd_sim && (k == 11 + 16 * n);
            step(k + 1);
        end
        data_read      = 1'b0;
        serial_data_in = 1'b1;
        for (int i = 0; i < 3; i++)
            step(total + 1 + i);
        if (mcr_at < 0) begin
            if (exp_full && !rd_sim)
                exp_ovr = 1'b1;
            exp_full = 1'b1;
        end
    endtask

    task automatic check_frame(input string tag);
        check($sformatf("%s.dv_count", tag), dv_count, 1);
        check($sformatf("%s.dv_latency", tag), dv_e, exp_e);
        check($sformatf("%s.data_out", tag), 32'(data_out), 32'(exp_data));
        check($sformatf("%s.parity_error", tag), 32'(parity_error), 32'(exp_perr));
        check($sformatf("%s.framing_error", tag), 32'(framing_error), 32'(exp_ferr));
        check($sformatf("%s.break_detect", tag), 32'(break_detect), 32'(exp_brk));
        check($sformatf("%s.rx_full", tag), 32'(rx_full), 32'(exp_full));
        check($sformatf("%s.overrun", tag), 32'(overrun_error), 32'(exp_ovr));
        if (was_empty) begin
            check($sformatf("%s.nrts_at_dv", tag), 32'(nrts_at_dv), 32'd0);
            check($sformatf("%s.nrts_after", tag), 32'(nrts_after), 32'd1);
        end
    endtask

    task automatic read_word;
        data_read = 1'b1;
        step(0);
        data_read = 1'b0;
        if (exp_full) begin
            exp_full = 1'b0;
            exp_ovr  = 1'b0;
        end
        step(0);
        step(0);
    endtask

    initial begin
        logic [3:0] rdl;
        reset          = 1'b0;
        serial_data_in = 1'b1;
        MCR1           = 1'b1;
        data_length    = 4'd8;
        parity_en      = 1'b0;
        parity_odd     = 1'b0;
        num_stop_bit   = 2'b01;
        data_read      = 1'b0;
        dv_e           = -1;
        tick;
        tick;
        check("rst.data_out", 32'(data_out), 32'd0);
        check("rst.data_valid", 32'(data_valid), 32'd0);
        check("rst.rx_full", 32'(rx_full), 32'd0);
        check("rst.errors", 32'({parity_error, framing_error, break_detect, overrun_error}), 32'd0);
        check("rst.n_RTS", 32'(n_RTS), 32'd1);
        reset = 1'b1;
        repeat (3) tick;
        check("rts_enabled", 32'(n_RTS), 32'd0);

        // 8N1 0xA5
        send_frame(9'h0A5, 4'd8, 0, 0, 2'b01, 0, 0, 0, -1, -1);
        check_frame("8n1_a5");
        read_word;
        check("read.rx_full", 32'(rx_full), 32'd0);
        check("read.n_RTS", 32'(n_RTS), 32'd0);

        // 7E2 0x35, good then bad parity
        send_frame(9'h035, 4'd7, 1, 0, 2'b11, 0, 0, 0, -1, -1);
        check_frame("7e2_good");
        read_word;
        send_frame(9'h035, 4'd7, 1, 0, 2'b11, 1, 0, 0, -1, -1);
        check_frame("7e2_bad");
        read_word;

        // 9O1.5
        send_frame(9'h1B3, 4'd9, 1, 1, 2'b10, 0, 0, 0, -1, -1);
        check_frame("9o15");
        read_word;

        // 5-cycle glitch is a false start
        dv_count = 0;
        serial_data_in = 1'b0;
        repeat (5) step(0);
        serial_data_in = 1'b1;
        repeat (40) step(0);
        check("glitch.dv_count", dv_count, 0);
        check("glitch.rx_full", 32'(rx_full), 32'd0);

        send_frame(9'h03C, 4'd8, 0, 0, 2'b01, 0, 1, 0, -1, -1);
        check_frame("framing");
        read_word;

        // Overrun, then read coincident with completion
        send_frame(9'h011, 4'd8, 0, 0, 2'b01, 0, 0, 0, -1, -1);
        check_frame("ovr_first");
        send_frame(9'h022, 4'd8, 0, 0, 2'b01, 0, 0, 0, -1, -1);
        check_frame("ovr_second");
        read_word;
        check("ovr_cleared", 32'(overrun_error), 32'd0);
        send_frame(9'h033, 4'd8, 0, 0, 2'b01, 0, 0, 0, -1, -1);
        check_frame("sim_first");
        send_frame(9'h044, 4'd8, 0, 0, 2'b01, 0, 0, 1, -1, -1);
        check_frame("sim_read");
        read_word;

        // Break: line low for two 9E1 frame times
        data_length  = 4'd9;
        parity_en    = 1'b1;
        parity_odd   = 1'b0;
        num_stop_bit = 2'b01;
        dv_count   = 0;
        dv_e       = -1;
        exp_data   = 9'd0;
        exp_perr   = 1'b0;
        exp_ferr   = 1'b1;
        exp_brk    = 1'b1;
        exp_e      = 12 + 16 * 11;
        was_empty  = !exp_full;
        serial_data_in = 1'b0;
        for (int e = 1; e <= 384; e++)
            step(e);
        serial_data_in = 1'b1;
        repeat (3) step(385);
        exp_full = 1'b1;
        check_frame("break");
        read_word;
        send_frame(9'h0E7, 4'd8, 0, 0, 2'b01, 0, 0, 0, -1, -1);
        check_frame("after_break");

        // Reset mid-DATA with an unread word held
        send_frame(9'h0C3, 4'd8, 0, 0, 2'b01, 0, 0, 0, 16 * 4, -1);
        check("rstmid.dv_count", dv_count, 0);
        reset = 1'b0;
        tick;
        exp_full = 1'b0;
        exp_ovr  = 1'b0;
        check("rstmid.data_out", 32'(data_out), 32'd0);
        check("rstmid.rx_full", 32'(rx_full), 32'd0);
        check("rstmid.errors", 32'({parity_error, framing_error, break_detect, overrun_error}), 32'd0);
        check("rstmid.n_RTS", 32'(n_RTS), 32'd1);
        reset = 1'b1;
        repeat (30) tick;
        send_frame(9'h05A, 4'd8, 0, 0, 2'b01, 0, 0, 0, -1, -1);
        check_frame("post_reset_5a");
        read_word;

        // MCR1 dropped mid-frame
        send_frame(9'h0C3, 4'd8, 0, 0, 2'b01, 0, 0, 0, -1, 16 * 4);
        check("mcr.dv_count", dv_count, 0);
        check("mcr.n_RTS", 32'(n_RTS), 32'd1);
        MCR1 = 1'b1;
        repeat (3) tick;
        check("mcr.n_RTS_back", 32'(n_RTS), 32'd0);
        send_frame(9'h05A, 4'd8, 0, 0, 2'b01, 0, 0, 0, -1, -1);
        check_frame("post_mcr_5a");
        read_word;

        // Randomized formats, including an illegal length that means 8
        for (int i = 0; i < 8; i++) begin
            int r;
            r   = int'($urandom_range(0, 5));
            rdl = (r == 5) ? 4'd12 : 4'(5 + r);
            send_frame(9'($urandom), rdl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, 0, -1, -1);
            check_frame($sformatf("rand%0d", i));
            read_word;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
